imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_if.sv | 13 +
 rtl/imem_loader.sv | 95 +++++++++
 tb/tb_imem_loader.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream receive handshake and instruction-memory write port of the image loader.
interface imem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;

  // master: the loader itself; slave: byte source plus memory side
  modport master (input rx_data, rx_valid, output rx_ready, imem_we, imem_waddr, imem_wdata);
  modport slave  (output rx_data, rx_valid, input rx_ready, imem_we, imem_waddr, imem_wdata);
endinterface

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte image and writes it
// word by word into instruction memory while holding the CPU in reset.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  imem_loader_if.master bus,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error,
  output logic [15:0] word_count
);

  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERROR} state_t;

  state_t      state, nxt;
  logic [15:0] len;
  logic [23:0] asm_q;
  logic [1:0]  bcnt;
  logic [7:0]  csum;
  logic        take;
  logic        restart;

  assign bus.rx_ready = (state == LEN_LO) || (state == LEN_HI) || (state == DATA) || (state == CHECK);
  assign bus.imem_we  = (state == WRITE);
  assign cpu_hold     = (state != DONE);
  assign load_done    = (state == DONE);
  assign load_error   = (state == ERROR);
  assign take         = bus.rx_valid && bus.rx_ready;
  assign restart      = start && ((state == IDLE) || (state == DONE) || (state == ERROR));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERROR: if (start) nxt = LEN_LO;
      LEN_LO: if (take) nxt = LEN_HI;
      LEN_HI: if (take) begin
        if ({bus.rx_data, len[7:0]} == 16'd0)                      nxt = CHECK;
        else if ({16'd0, bus.rx_data, len[7:0]} > 32'(MAX_WORDS)) nxt = ERROR;
        else                                                       nxt = DATA;
      end
      DATA:   if (take && bcnt == 2'd3) nxt = WRITE;
      // word_count still holds the index of the word being written here
      WRITE:  nxt = (word_count + 16'd1 == len) ? CHECK : DATA;
      CHECK:  if (take) nxt = (bus.rx_data == csum) ? DONE : ERROR;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len            <= '0;
      asm_q          <= '0;
      bcnt           <= '0;
      csum           <= '0;
      word_count     <= '0;
      bus.imem_waddr <= '0;
      bus.imem_wdata <= '0;
    end else begin
      if (restart) begin
        len        <= '0;
        asm_q      <= '0;
        bcnt       <= '0;
        csum       <= '0;
        word_count <= '0;
      end
      case (state)
        LEN_LO: if (take) len[7:0]  <= bus.rx_data;
        LEN_HI: if (take) len[15:8] <= bus.rx_data;
        DATA: if (take) begin
          csum <= csum ^ bus.rx_data;
          bcnt <= bcnt + 2'd1;
          // address/data are registered here so they are stable for the whole WRITE cycle
          if (bcnt == 2'd3) begin
            bus.imem_wdata <= {bus.rx_data, asm_q};
            bus.imem_waddr <= BASE_ADDR + {14'd0, word_count, 2'b00};
          end else begin
            asm_q <= {bus.rx_data, asm_q[23:8]};
          end
        end
        WRITE: word_count <= word_count + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded bench: two loaders (base 0 and base FFFF_FFFC) fed the same byte stream.
module tb_imem_loader;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  int         checks = 0;
  int         errors = 0;

  logic [63:0] exp_a[$];
  logic [63:0] exp_b[$];
  logic [7:0]  stim[$];

  logic        hold_a, done_a, err_a, hold_b, done_b, err_b;
  logic [15:0] wc_a, wc_b;

  imem_loader_if ifa ();
  imem_loader_if ifb ();

  assign ifa.rx_data  = rx_data;
  assign ifa.rx_valid = rx_valid;
  assign ifb.rx_data  = rx_data;
  assign ifb.rx_valid = rx_valid;

  imem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(256)) dut_a (
    .clk(clk), .reset(reset), .start(start), .bus(ifa.master),
    .cpu_hold(hold_a), .load_done(done_a), .load_error(err_a), .word_count(wc_a));

  imem_loader #(.BASE_ADDR(32'hFFFF_FFFC), .MAX_WORDS(256)) dut_b (
    .clk(clk), .reset(reset), .start(start), .bus(ifb.master),
    .cpu_hold(hold_b), .load_done(done_b), .load_error(err_b), .word_count(wc_b));

  always #5 clk = ~clk;

  // Write monitors: every imem_we cycle pops one expected {addr,data}
  always @(negedge clk) begin
    if (ifa.imem_we) begin
      checks++;
      if (exp_a.size() == 0) begin
        errors++;
        $display("FAIL write_a unexpected: addr=%h data=%h", ifa.imem_waddr, ifa.imem_wdata);
      end else begin
        logic [63:0] e;
        e = exp_a.pop_front();
        if ({ifa.imem_waddr, ifa.imem_wdata} !== e) begin
          errors++;
          $display("FAIL write_a: got %h/%h want %h/%h", ifa.imem_waddr, ifa.imem_wdata, e[63:32], e[31:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (ifb.imem_we) begin
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL write_b unexpected: addr=%h data=%h", ifb.imem_waddr, ifb.imem_wdata);
      end else begin
        logic [63:0] e;
        e = exp_b.pop_front();
        if ({ifb.imem_waddr, ifb.imem_wdata} !== e) begin
          errors++;
          $display("FAIL write_b: got %h/%h want %h/%h", ifb.imem_waddr, ifb.imem_wdata, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic push_two_words();
    exp_a.push_back({32'h0000_0000, 32'h0000_0013});
    exp_a.push_back({32'h0000_0004, 32'h0000_006F});
    exp_b.push_back({32'hFFFF_FFFC, 32'h0000_0013});
    exp_b.push_back({32'h0000_0000, 32'h0000_006F});
  endtask

  // Presents stim bytes at negedges; hold=1 keeps rx_valid high throughout
  task automatic drive(input bit hold, output int n_acc, output int n_low, output int n_low_we);
    int idx = 0;
    int cyc = 0;
    n_acc = 0; n_low = 0; n_low_we = 0;
    while (idx < stim.size() && cyc < 300) begin
      @(negedge clk);
      cyc++;
      rx_valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
      rx_data  = stim[idx];
      if (rx_valid && ifa.rx_ready) begin
        idx++;
        n_acc++;
      end else if (!ifa.rx_ready) begin
        n_low++;
        if (ifa.imem_we) n_low_we++;
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'hA5;
    checks++;
    if (idx != stim.size()) begin
      errors++;
      $display("FAIL drive_timeout: accepted %0d of %0d bytes", idx, stim.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({ifa.rx_ready, ifa.imem_we, hold_a, done_a, err_a} !== 5'b00100) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00100", {ifa.rx_ready, ifa.imem_we, hold_a, done_a, err_a});
    end
    checks++;
    if ({ifa.imem_waddr, ifa.imem_wdata, wc_a} !== 80'd0) begin
      errors++;
      $display("FAIL reset_regs: addr=%h data=%h wc=%0d want 0", ifa.imem_waddr, ifa.imem_wdata, wc_a);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ifa.rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready: got %b want 0", ifa.rx_ready);
    end
  endtask

  task automatic test_basic_load();
    int a, l, lw;
    push_two_words();
    pulse_start();
    checks++;
    if (ifa.rx_ready !== 1'b1 || hold_a !== 1'b1) begin
      errors++;
      $display("FAIL start_ready: ready=%b hold=%b want 1/1", ifa.rx_ready, hold_a);
    end
    stim = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C};
    drive(1'b0, a, l, lw);
    checks++;
    if ({done_a, err_a, hold_a, wc_a} !== {3'b100, 16'd2}) begin
      errors++;
      $display("FAIL basic_status: done=%b err=%b hold=%b wc=%0d want 1/0/0/2", done_a, err_a, hold_a, wc_a);
    end
    checks++;
    if ({done_b, wc_b} !== {1'b1, 16'd2}) begin
      errors++;
      $display("FAIL basic_status_b: done=%b wc=%0d want 1/2", done_b, wc_b);
    end
    checks++;
    if (ifa.imem_waddr !== 32'h4 || ifa.imem_wdata !== 32'h6F || ifa.rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold: addr=%h data=%h ready=%b want 4/6f/0", ifa.imem_waddr, ifa.imem_wdata, ifa.rx_ready);
    end
    checks++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      errors++;
      $display("FAIL basic_missing_writes: left a=%0d b=%0d want 0", exp_a.size(), exp_b.size());
    end
  endtask

  task automatic test_zero_len();
    int a, l, lw;
    pulse_start();
    checks++;
    if ({done_a, hold_a, wc_a} !== {2'b01, 16'd0}) begin
      errors++;
      $display("FAIL restart_clear: done=%b hold=%b wc=%0d want 0/1/0", done_a, hold_a, wc_a);
    end
    stim = {8'h00, 8'h00, 8'h00};
    drive(1'b0, a, l, lw);
    checks++;
    if ({done_a, err_a, hold_a, wc_a} !== {3'b100, 16'd0}) begin
      errors++;
      $display("FAIL zero_len_ok: done=%b err=%b hold=%b wc=%0d want 1/0/0/0", done_a, err_a, hold_a, wc_a);
    end
    pulse_start();
    stim = {8'h00, 8'h00, 8'h01};
    drive(1'b0, a, l, lw);
    checks++;
    if ({done_a, err_a, hold_a} !== 3'b011) begin
      errors++;
      $display("FAIL bad_checksum: done=%b err=%b hold=%b want 0/1/1", done_a, err_a, hold_a);
    end
  endtask

  task automatic test_too_long();
    int a, l, lw;
    pulse_start();
    checks++;
    if (err_a !== 1'b0) begin
      errors++;
      $display("FAIL restart_from_error: err=%b want 0", err_a);
    end
    stim = {8'h01, 8'h01};
    drive(1'b0, a, l, lw);
    checks++;
    if ({err_a, done_a, ifa.rx_ready, hold_a} !== 4'b1001) begin
      errors++;
      $display("FAIL too_long: err=%b done=%b ready=%b hold=%b want 1/0/0/1", err_a, done_a, ifa.rx_ready, hold_a);
    end
    // a stray start-free byte must not be taken in ERROR
    @(negedge clk); rx_valid = 1'b1; rx_data = 8'h55;
    checks++;
    if (ifa.rx_ready !== 1'b0 || wc_a !== 16'd0) begin
      errors++;
      $display("FAIL error_idle: ready=%b wc=%0d want 0/0", ifa.rx_ready, wc_a);
    end
    @(negedge clk); rx_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int a, l, lw;
    push_two_words();
    pulse_start();
    stim = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C};
    drive(1'b1, a, l, lw);
    checks++;
    if (a != 11 || l != 2 || lw != 2) begin
      errors++;
      $display("FAIL b2b_handshake: acc=%0d low=%0d low_we=%0d want 11/2/2", a, l, lw);
    end
    checks++;
    if ({done_a, err_a, hold_a, wc_a} !== {3'b100, 16'd2} || exp_a.size() != 0 || exp_b.size() != 0) begin
      errors++;
      $display("FAIL b2b_status: done=%b err=%b hold=%b wc=%0d left=%0d want 1/0/0/2/0", done_a, err_a, hold_a, wc_a, exp_a.size());
    end
  endtask

  task automatic test_reset_mid();
    int a, l, lw;
    pulse_start();
    stim = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00};
    drive(1'b1, a, l, lw);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({ifa.rx_ready, ifa.imem_we, hold_a, done_a, err_a} !== 5'b00100 ||
        {ifa.imem_waddr, ifa.imem_wdata, wc_a} !== 80'd0) begin
      errors++;
      $display("FAIL mid_reset: rdy=%b we=%b hold=%b addr=%h data=%h wc=%0d", ifa.rx_ready, ifa.imem_we,
               hold_a, ifa.imem_waddr, ifa.imem_wdata, wc_a);
    end
    @(negedge clk); reset = 1'b0;
    rx_valid = 1'b1; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (ifa.rx_ready !== 1'b0 || wc_a !== 16'd0) begin
      errors++;
      $display("FAIL needs_start: ready=%b wc=%0d want 0/0", ifa.rx_ready, wc_a);
    end
    rx_valid = 1'b0;
    push_two_words();
    pulse_start();
    stim = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C};
    drive(1'b0, a, l, lw);
    checks++;
    if ({done_a, wc_a, done_b} !== {1'b1, 16'd2, 1'b1} || exp_a.size() != 0 || exp_b.size() != 0) begin
      errors++;
      $display("FAIL reload: done=%b wc=%0d done_b=%b left=%0d want 1/2/1/0", done_a, wc_a, done_b, exp_a.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_zero_len();
    test_too_long();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
